uart_fifo_bridge: RTL and testbench
===================================

// Module: uart_fifo_bridge
// PURPOSE
//  Buffered byte bridge between the SoC bus decode and the UART core, with one FIFO per direction.
//  Bus side: single-cycle push/pop strobes. UART side: drives the core's wr/rd strobes and tracks
//  busy/valid, so software can burst bytes without polling busy. Instantiated in soc next to the
//  uart instance; replaces the direct uart_wr/uart_rd strobe registers.
// PARAMETERS
//  DEPTH  16  entries per FIFO; power of two, >= 2. LW = $clog2(DEPTH)+1 is the level width.
// PORTS
//  clk             in   1   system clock; all logic on posedge
//  reset_i         in   1   asynchronous, active-high reset
//  wr_i            in   1   bus push strobe for the TX FIFO, one cycle per byte
//  tx_data_i       in   8   byte pushed with wr_i
//  rd_i            in   1   bus pop strobe for the RX FIFO, one cycle per byte
//  rx_data_o       out  8   RX FIFO head (show-ahead); 8'd0 when RX is empty
//  clr_i           in   1   clears the sticky error bits
//  status_o        out  8   [0]tx_full [1]rx_avail [2]tx_empty [3]rx_full [4]tx_ovf [5]rx_unf; [7:6]=0
//  tx_level_o      out  LW  TX FIFO occupancy
//  rx_level_o      out  LW  RX FIFO occupancy
//  uart_wr_o       out  1   one-cycle start strobe to uart.wr_i
//  uart_tx_data_o  out  8   byte to uart.tx_data_i
//  uart_busy_i     in   1   uart.busy_o; rises no later than 1 cycle after uart_wr_o
//  uart_rd_o       out  1   one-cycle acknowledge to uart.rd_i
//  uart_rx_data_i  in   8   uart.rx_data_o; valid while uart_valid_i is high
//  uart_valid_i    in   1   uart.valid_o; high while a received byte is held; drops after uart_rd_o
// BEHAVIOUR
//  Reset: both FIFOs empty, both FSMs IDLE, all outputs 0 except status_o[2]=1 (tx_empty).
//   Reset mid-operation aborts the bridge only; a frame already started in the UART completes.
//  FIFO rules (identical for TX and RX):
//   - Push when full: dropped. For TX, sets tx_ovf (sticky).
//   - Pop when empty: ignored. For RX, sets rx_unf (sticky).
//   - Push+pop in the same cycle when full: both take effect; level unchanged.
//   - Push+pop in the same cycle when empty: push takes effect; pop is an underflow.
//   - Pointers wrap modulo DEPTH. Level is in 0..DEPTH.
//   - clr_i clears ovf/unf. An error event in the same cycle as clr_i wins (the bit stays set).
//  TX FSM (IDLE, LAUNCH, GUARD, DRAIN):
//   - IDLE -> LAUNCH when the TX FIFO is not empty. Pop the head into the uart_tx_data_o register.
//   - LAUNCH: uart_wr_o=1 for exactly this one cycle -> GUARD.
//   - GUARD: one cycle, which absorbs the busy rise latency -> DRAIN.
//   - DRAIN -> IDLE on the first cycle with uart_busy_i=0.
//   - Latency: byte pushed at cycle N into an empty FIFO with the FSM in IDLE -> uart_wr_o high at N+2.
//   - Back-to-back bytes: the next LAUNCH comes no earlier than 1 cycle after busy falls.
//   - uart_tx_data_o holds from LAUNCH until the next pop.
//  RX FSM (IDLE, ACK, WAIT):
//   - IDLE -> ACK when uart_valid_i=1 and the RX FIFO is not full. Push uart_rx_data_i on that edge.
//   - ACK: uart_rd_o=1 for one cycle -> WAIT.
//   - WAIT -> IDLE when uart_valid_i=0. This prevents a double push of the same byte.
//   - RX FIFO full: no ack is issued, and the byte stays held in the UART (backpressure).
//     A UART-internal overrun is not visible here.
//   - Latency: valid rises at cycle M -> rx_avail=1 and uart_rd_o=1 at M+1.
//   - A bus rd_i in the same cycle as an RX push follows the FIFO simultaneity rules above.
//  Outputs: uart_wr_o and uart_rd_o are registered. status_o and the levels are registered
//   FIFO state. rx_data_o is a combinational mux of the head entry.
// STRUCTURE
//  Package uart_bridge_pkg:
//   - tx_state_t and rx_state_t enums
//   - STAT_TX_FULL..STAT_RX_UNF bit-index localparams
//  Sub-module sync_fifo #(WIDTH, DEPTH):
//   - ports push, pop, din, dout (show-ahead), full, empty, level, ovf_pulse, unf_pulse
//   - instantiated twice
//  The top level holds the two FSMs, the sticky flags and the status packing.
// TESTING
//  - Reset, then push 0x41 with uart_busy_i modelled 1 cycle after wr for 20 cycles
//    -> uart_wr_o at N+2, uart_tx_data_o=0x41; tx_empty=1 after the pop.
//  - Push 17 bytes back-to-back with DEPTH=16 while the UART model is busy
//    -> tx_level=16, tx_ovf=1, byte 17 lost. Bytes 1..16 reach the UART in order, one launch per busy-low.
//  - Model valid with data 0x5A held until rd -> uart_rd_o single pulse, rx_data_o=0x5A,
//    rx_level=1, exactly one push.
//  - Fill RX to 16, then present valid with 0x99 -> no uart_rd_o.
//    Then rd_i once -> ack and push of 0x99 follow within 2 cycles, level back to 16.
//  - rd_i on empty RX -> rx_unf=1, rx_data_o=0. clr_i -> rx_unf=0.
//    clr_i coincident with a new underflow -> rx_unf stays 1.
//  - Assert reset_i asynchronously while in DRAIN with 3 bytes queued
//    -> outputs 0 immediately (status_o=8'h04), levels 0, no further uart_wr_o after release.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared types and status-bit positions for the UART FIFO bridge.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LAUNCH,
        TX_GUARD,
        TX_DRAIN
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ACK,
        RX_WAIT
    } rx_state_t;

    // Bit positions inside status_o; [7:6] are always zero.
    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_RX_AVAIL = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_TX_OVF   = 4;
    localparam int STAT_RX_UNF   = 5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. A push into a full FIFO is accepted only when
// a pop happens in the same cycle; a pop from an empty FIFO is always ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic             ovf_pulse,
    output logic             unf_pulse
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign ovf_pulse = push && !do_push;
    assign unf_pulse = pop && empty;
    assign dout      = empty ? '0 : mem[rd_ptr];

    // Storage write.
    // NOTE: the data array has no reset; level and pointers decide what is valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the pointers wrap on their own.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffered byte bridge between the bus strobes and the UART core: a TX FIFO
// drained by a launch FSM, an RX FIFO filled by an acknowledge FSM, plus
// sticky overflow/underflow flags packed into a status byte.
module uart_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          wr_i,
    input  logic [7:0]    tx_data_i,
    input  logic          rd_i,
    output logic [7:0]    rx_data_o,
    input  logic          clr_i,
    output logic [7:0]    status_o,
    output logic [LW-1:0] tx_level_o,
    output logic [LW-1:0] rx_level_o,
    output logic          uart_wr_o,
    output logic [7:0]    uart_tx_data_o,
    input  logic          uart_busy_i,
    output logic          uart_rd_o,
    input  logic [7:0]    uart_rx_data_i,
    input  logic          uart_valid_i
);

    tx_state_t  tx_state, tx_next;
    rx_state_t  rx_state, rx_next;

    logic       tx_pop, tx_full, tx_empty, tx_ovf_pulse;
    logic       rx_push, rx_full, rx_empty, rx_unf_pulse;
    logic [7:0] tx_head;
    logic       tx_unf_unused, rx_ovf_unused;
    logic       tx_ovf, rx_unf;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset_i   (reset_i),
        .push      (wr_i),
        .pop       (tx_pop),
        .din       (tx_data_i),
        .dout      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level_o),
        .ovf_pulse (tx_ovf_pulse),
        .unf_pulse (tx_unf_unused)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset_i   (reset_i),
        .push      (rx_push),
        .pop       (rd_i),
        .din       (uart_rx_data_i),
        .dout      (rx_data_o),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level_o),
        .ovf_pulse (rx_ovf_unused),
        .unf_pulse (rx_unf_pulse)
    );

    // TX next state: pop one byte, strobe the UART, absorb the busy-rise latency, wait for busy to drop.
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_next = TX_LAUNCH;
                end
            end
            TX_LAUNCH: tx_next = TX_GUARD;
            TX_GUARD:  tx_next = TX_DRAIN;
            TX_DRAIN: begin
                if (!uart_busy_i) begin
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // TX state, registered write strobe and the byte held for the UART.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            tx_state       <= TX_IDLE;
            uart_wr_o      <= 1'b0;
            uart_tx_data_o <= '0;
        end else begin
            tx_state  <= tx_next;
            uart_wr_o <= (tx_next == TX_LAUNCH);
            if (tx_pop) begin
                uart_tx_data_o <= tx_head;
            end
        end
    end

    // RX next state: capture a held byte only when there is room, ack once, then wait for valid to drop.
    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (uart_valid_i && !rx_full) begin
                    rx_push = 1'b1;
                    rx_next = RX_ACK;
                end
            end
            RX_ACK: rx_next = RX_WAIT;
            RX_WAIT: begin
                if (!uart_valid_i) begin
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // RX state and registered acknowledge strobe.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rx_state  <= RX_IDLE;
            uart_rd_o <= 1'b0;
        end else begin
            rx_state  <= rx_next;
            uart_rd_o <= (rx_next == RX_ACK);
        end
    end

    // Sticky error flags; a new error event outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_pulse | (tx_ovf & ~clr_i);
            rx_unf <= rx_unf_pulse | (rx_unf & ~clr_i);
        end
    end

    // Status byte packing from registered FIFO state.
    always_comb begin
        status_o                = '0;
        status_o[STAT_TX_FULL]  = tx_full;
        status_o[STAT_RX_AVAIL] = !rx_empty;
        status_o[STAT_TX_EMPTY] = tx_empty;
        status_o[STAT_RX_FULL]  = rx_full;
        status_o[STAT_TX_OVF]   = tx_ovf;
        status_o[STAT_RX_UNF]   = rx_unf;
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: behavioural UART models on both
// sides, a TX scoreboard checked at every launch, an RX scoreboard checked at
// every bus pop, a vector table for RX bus operations, and directed corner cases.
module tb_uart_fifo_bridge;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          wr_i;
    logic [7:0]    tx_data_i;
    logic          rd_i;
    logic [7:0]    rx_data_o;
    logic          clr_i;
    logic [7:0]    status_o;
    logic [LW-1:0] tx_level_o;
    logic [LW-1:0] rx_level_o;
    logic          uart_wr_o;
    logic [7:0]    uart_tx_data_o;
    logic          uart_busy_i = 1'b0;
    logic          uart_rd_o;
    logic [7:0]    uart_rx_data_i = 8'h00;
    logic          uart_valid_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .wr_i           (wr_i),
        .tx_data_i      (tx_data_i),
        .rd_i           (rd_i),
        .rx_data_o      (rx_data_o),
        .clr_i          (clr_i),
        .status_o       (status_o),
        .tx_level_o     (tx_level_o),
        .rx_level_o     (rx_level_o),
        .uart_wr_o      (uart_wr_o),
        .uart_tx_data_o (uart_tx_data_o),
        .uart_busy_i    (uart_busy_i),
        .uart_rd_o      (uart_rd_o),
        .uart_rx_data_i (uart_rx_data_i),
        .uart_valid_i   (uart_valid_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // UART transmitter model: busy rises one cycle after the write strobe and lasts busy_len cycles.
    int         busy_len   = 20;
    logic       busy_pend  = 1'b0;
    int         busy_cnt   = 0;
    int         launch_cnt = 0;
    logic [7:0] tx_q [$];

    always @(negedge clk) begin
        if (uart_wr_o) begin
            launch_cnt++;
            check("launch_while_busy", 32'(uart_busy_i), 32'd0);
            check("launch_expected", 32'(tx_q.size() != 0), 32'd1);
            if (tx_q.size() != 0) begin
                check("launch_data", 32'(uart_tx_data_o), 32'(tx_q.pop_front()));
            end
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) uart_busy_i = 1'b0;
        end
        if (busy_pend) begin
            uart_busy_i = 1'b1;
            busy_cnt    = busy_len;
            busy_pend   = 1'b0;
        end
        if (uart_wr_o) busy_pend = 1'b1;
    end

    // UART receiver model: holds each byte valid until acknowledged, then leaves a short gap.
    logic [7:0] rx_src [$];
    int         rd_cnt = 0;
    int         rx_gap = 0;

    always @(negedge clk) begin
        if (uart_rd_o) begin
            rd_cnt++;
            if (uart_valid_i) begin
                uart_valid_i = 1'b0;
                rx_gap       = 2;
            end
        end else if (rx_gap > 0) begin
            rx_gap--;
        end else if (!uart_valid_i && rx_src.size() != 0) begin
            uart_rx_data_i = rx_src.pop_front();
            uart_valid_i   = 1'b1;
        end
    end

    // RX scoreboard: bytes expected at the bus, compared on every pop.
    logic [7:0] rx_exp [$];

    task automatic bus_pop();
        check("rx_sb_nonempty", 32'(rx_exp.size() != 0), 32'd1);
        if (rx_exp.size() != 0) begin
            check("rx_pop_data", 32'(rx_data_o), 32'(rx_exp.pop_front()));
        end
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
    endtask

    typedef struct {
        logic          rd;
        logic          clr;
        logic [LW-1:0] lvl;
        logic [7:0]    data;
        logic          unf;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, actual running, expected done");
        $fatal(1);
    end

    initial begin
        int t;
        int r0;
        int l0;
        logic seen;

        // RX bus operations on a FIFO preloaded with 0x11, 0x22, 0x33.
        tbl[0] = '{1'b1, 1'b0, 5'd2, 8'h22, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 5'd2, 8'h22, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 5'd1, 8'h33, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 5'd0, 8'h00, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 5'd0, 8'h00, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b0};

        reset_i   = 1'b1;
        wr_i      = 1'b0;
        tx_data_i = 8'h00;
        rd_i      = 1'b0;
        clr_i     = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_status", 32'(status_o), 32'h04);
        check("rst_tx_level", 32'(tx_level_o), 32'd0);
        check("rst_rx_level", 32'(rx_level_o), 32'd0);
        check("rst_rx_data", 32'(rx_data_o), 32'd0);
        check("rst_uart_wr", 32'(uart_wr_o), 32'd0);
        check("rst_uart_rd", 32'(uart_rd_o), 32'd0);
        check("rst_uart_tx_data", 32'(uart_tx_data_o), 32'd0);
        reset_i = 1'b0;
        tick();

        // Single byte: launch two cycles after the push.
        tx_q.push_back(8'h41);
        wr_i      = 1'b1;
        tx_data_i = 8'h41;
        tick();
        wr_i = 1'b0;
        check("tx1_wr_n1", 32'(uart_wr_o), 32'd0);
        check("tx1_level_n1", 32'(tx_level_o), 32'd1);
        tick();
        check("tx1_wr_n2", 32'(uart_wr_o), 32'd1);
        check("tx1_data_n2", 32'(uart_tx_data_o), 32'h41);
        check("tx1_empty_n2", 32'(status_o[2]), 32'd1);
        tick();
        check("tx1_wr_n3", 32'(uart_wr_o), 32'd0);
        repeat (30) tick();
        check("tx1_data_hold", 32'(uart_tx_data_o), 32'h41);
        check("tx1_launches", 32'(launch_cnt), 32'd1);

        // Burst of 17 while the UART is busy with a primer byte.
        busy_len = 40;
        tx_q.push_back(8'hA0);
        wr_i      = 1'b1;
        tx_data_i = 8'hA0;
        tick();
        wr_i = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 17; i++) begin
            wr_i      = 1'b1;
            tx_data_i = 8'(8'h01 + i);
            if (i < DEPTH) tx_q.push_back(8'(8'h01 + i));
            tick();
        end
        wr_i = 1'b0;
        check("burst_level", 32'(tx_level_o), 32'd16);
        check("burst_full", 32'(status_o[0]), 32'd1);
        check("burst_ovf", 32'(status_o[4]), 32'd1);
        busy_len = 4;
        t = 0;
        while ((tx_q.size() != 0 || tx_level_o != '0) && t < 600) begin
            tick();
            t++;
        end
        check("burst_drain_in_time", 32'(t < 600), 32'd1);
        repeat (10) tick();
        check("burst_launches", 32'(launch_cnt), 32'd18);
        check("burst_ovf_sticky", 32'(status_o[4]), 32'd1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("burst_ovf_clr", 32'(status_o[4]), 32'd0);

        // RX single byte: ack and availability one cycle after valid rises.
        r0 = rd_cnt;
        rx_src.push_back(8'h5A);
        rx_exp.push_back(8'h5A);
        tick();
        check("rx1_rd_m1", 32'(uart_rd_o), 32'd1);
        check("rx1_avail_m1", 32'(status_o[1]), 32'd1);
        check("rx1_data_m1", 32'(rx_data_o), 32'h5A);
        tick();
        check("rx1_rd_m2", 32'(uart_rd_o), 32'd0);
        repeat (5) tick();
        check("rx1_acks", 32'(rd_cnt - r0), 32'd1);
        check("rx1_level", 32'(rx_level_o), 32'd1);
        bus_pop();
        check("rx1_level_after_pop", 32'(rx_level_o), 32'd0);
        check("rx1_data_empty", 32'(rx_data_o), 32'd0);

        // RX fill to 16, then backpressure on a 17th byte.
        for (int i = 0; i < DEPTH; i++) begin
            rx_src.push_back(8'(8'h80 + i));
            rx_exp.push_back(8'(8'h80 + i));
        end
        t = 0;
        while (rx_level_o != 5'd16 && t < 300) begin
            tick();
            t++;
        end
        check("rxfill_in_time", 32'(t < 300), 32'd1);
        repeat (6) tick();
        r0 = rd_cnt;
        rx_src.push_back(8'h99);
        rx_exp.push_back(8'h99);
        repeat (10) tick();
        check("rxfull_no_ack", 32'(rd_cnt - r0), 32'd0);
        check("rxfull_held", 32'(uart_valid_i), 32'd1);
        check("rxfull_flag", 32'(status_o[3]), 32'd1);
        bus_pop();
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!seen) begin
                tick();
                seen = uart_rd_o;
            end
        end
        check("rxfull_ack_after_pop", 32'(seen), 32'd1);
        tick();
        check("rxfull_level_back", 32'(rx_level_o), 32'd16);
        check("rxfull_single_ack", 32'(rd_cnt - r0), 32'd1);
        for (int i = 0; i < DEPTH; i++) bus_pop();
        check("rxfull_drained", 32'(rx_level_o), 32'd0);

        // RX vector table: pops, underflow, clear and clear-vs-event precedence.
        rx_src.push_back(8'h11);
        rx_src.push_back(8'h22);
        rx_src.push_back(8'h33);
        t = 0;
        while (rx_level_o != 5'd3 && t < 100) begin
            tick();
            t++;
        end
        check("tbl_preload_in_time", 32'(t < 100), 32'd1);
        repeat (6) tick();
        check("tbl_preload_head", 32'(rx_data_o), 32'h11);
        for (int i = 0; i < 8; i++) begin
            rd_i  = tbl[i].rd;
            clr_i = tbl[i].clr;
            tick();
            rd_i  = 1'b0;
            clr_i = 1'b0;
            check($sformatf("tbl%0d_level", i), 32'(rx_level_o), 32'(tbl[i].lvl));
            check($sformatf("tbl%0d_data", i), 32'(rx_data_o), 32'(tbl[i].data));
            check($sformatf("tbl%0d_unf", i), 32'(status_o[5]), 32'(tbl[i].unf));
        end

        // Asynchronous reset while draining with three bytes queued.
        busy_len = 20;
        t = 0;
        while (uart_busy_i && t < 100) begin
            tick();
            t++;
        end
        for (int i = 0; i < 4; i++) begin
            wr_i      = 1'b1;
            tx_data_i = 8'(8'hC1 + i);
            tx_q.push_back(8'(8'hC1 + i));
            tick();
        end
        wr_i = 1'b0;
        repeat (2) tick();
        check("arst_pre_level", 32'(tx_level_o), 32'd3);
        check("arst_pre_busy", 32'(uart_busy_i), 32'd1);
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_status", 32'(status_o), 32'h04);
        check("arst_tx_level", 32'(tx_level_o), 32'd0);
        check("arst_rx_level", 32'(rx_level_o), 32'd0);
        check("arst_uart_tx_data", 32'(uart_tx_data_o), 32'd0);
        check("arst_uart_wr", 32'(uart_wr_o), 32'd0);
        tx_q.delete();
        l0 = launch_cnt;
        tick();
        reset_i = 1'b0;
        repeat (40) tick();
        check("arst_no_relaunch", 32'(launch_cnt - l0), 32'd0);
        check("arst_status_after", 32'(status_o), 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
